// File: rtl/ptwalker_if.sv
// rtl/ptwalker_if.sv - PTE read/write port between the page-table walker and the D$/bus arbiter
interface ptwalker_if #(
    parameter int PA_BITS = 56
);
    logic               HPTWReq;
    logic [PA_BITS-1:0] HPTWAdr;
    logic               HPTWWr;
    logic [63:0]        HPTWWrData;
    logic               HPTWValid;
    logic [63:0]        HPTWRdData;

    modport master (
        output HPTWReq, HPTWAdr, HPTWWr, HPTWWrData,
        input  HPTWValid, HPTWRdData
    );

    modport slave (
        input  HPTWReq, HPTWAdr, HPTWWr, HPTWWrData,
        output HPTWValid, HPTWRdData
    );
endinterface

// File: rtl/ptwalker.sv
// rtl/ptwalker.sv - Sv39/Sv48 hardware page-table walker servicing MMU TLB misses
// Optional A/D write-back of leaf PTEs is built when HPTW_ADUPDATE_EN is defined.
module ptwalker #(
    parameter int LEVELS  = 3,
    parameter int PA_BITS = 56,
    parameter int VA_BITS = 39
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_TLBMiss,
    input  logic               i_MissIsWrite,
    input  logic [VA_BITS-1:0] i_VAdr,
    input  logic [63:0]        i_SATP_REGW,
    input  logic               i_TLBFlush,
    ptwalker_if.master         hptw,
    output logic [63:0]        o_PTE,
    output logic [1:0]         o_PageTypeWriteVal,
    output logic               o_TLBWrite,
    output logic               o_WalkerPageFault,
    output logic               o_DisableTranslation
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CHECK,
`ifdef HPTW_ADUPDATE_EN
        S_UPDATE,
`endif
        S_LEAF,
        S_FAULT
    } state_t;

    localparam logic [1:0] TOP_LEVEL = 2'(LEVELS - 1);
    localparam logic [63:0] PTE_A = 64'h40;
    localparam logic [63:0] PTE_D = 64'h80;

    function automatic logic [8:0] vpn_of(input logic [VA_BITS-1:0] va, input logic [1:0] lvl);
        logic [VA_BITS-1:0] sh;
        sh = va >> (12 + 9 * int'(lvl));
        return sh[8:0];
    endfunction

    function automatic logic [PA_BITS-1:0] pte_adr(input logic [43:0] base, input logic [8:0] vpn);
        logic [55:0] full;
        full = {base, vpn, 3'b000};
        return full[PA_BITS-1:0];
    endfunction

    // PPN bits that must be zero for a leaf found at level lvl
    function automatic logic [43:0] sp_mask(input logic [1:0] lvl);
        return (44'd1 << (9 * int'(lvl))) - 44'd1;
    endfunction

    state_t             r_state;
    logic [1:0]         r_level;
    logic [VA_BITS-1:0] r_vadr;
    logic               r_miss_write;
    logic               r_abort;
    logic [63:0]        r_pte;
    logic               r_req;
    logic [PA_BITS-1:0] r_adr;
    logic               r_tlbwrite;
    logic               r_fault;
`ifdef HPTW_ADUPDATE_EN
    logic               r_wr;
    logic [63:0]        r_wrdata;
`endif

    logic [43:0]        w_pte_ppn;
    logic               w_leaf;
    logic               w_bad;
    logic               w_misaligned;
    logic               w_need_ad;
    logic               w_start;
    logic [PA_BITS-1:0] w_start_adr;
    logic [PA_BITS-1:0] w_next_adr;
    logic               w_unused;

    assign w_pte_ppn    = r_pte[53:10];
    assign w_leaf       = r_pte[1] | r_pte[3];
    assign w_bad        = ~r_pte[0] | (~r_pte[1] & r_pte[2]);
    assign w_misaligned = |(w_pte_ppn & sp_mask(r_level));
    assign w_need_ad    = ~r_pte[6] | (r_miss_write & ~r_pte[7]);
    assign w_start      = i_TLBMiss & ~i_TLBFlush & (i_SATP_REGW[63:60] != 4'd0);
    assign w_start_adr  = pte_adr(i_SATP_REGW[43:0], vpn_of(i_VAdr, TOP_LEVEL));
    assign w_next_adr   = pte_adr(w_pte_ppn, vpn_of(r_vadr, r_level - 2'd1));
    assign w_unused     = ^i_SATP_REGW[59:44];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_level      <= 2'd0;
            r_vadr       <= '0;
            r_miss_write <= 1'b0;
            r_abort      <= 1'b0;
            r_pte        <= 64'd0;
            r_req        <= 1'b0;
            r_adr        <= '0;
            r_tlbwrite   <= 1'b0;
            r_fault      <= 1'b0;
`ifdef HPTW_ADUPDATE_EN
            r_wr         <= 1'b0;
            r_wrdata     <= 64'd0;
`endif
        end else begin
            r_tlbwrite <= 1'b0;
            r_fault    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_vadr       <= i_VAdr;
                        r_miss_write <= i_MissIsWrite;
                        r_level      <= TOP_LEVEL;
                        r_adr        <= w_start_adr;
                        r_req        <= 1'b1;
                        r_abort      <= 1'b0;
                        r_state      <= S_READ;
                    end
                end
                // A flushed walk still waits for its response so the port never sees a dropped read
                S_READ: begin
                    if (i_TLBFlush) r_abort <= 1'b1;
                    if (hptw.HPTWValid) begin
                        r_req   <= 1'b0;
                        r_pte   <= hptw.HPTWRdData;
                        r_state <= (r_abort | i_TLBFlush) ? S_IDLE : S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (i_TLBFlush) begin
                        r_state <= S_IDLE;
                    end else if (w_bad || (w_leaf && w_misaligned) || (!w_leaf && r_level == 2'd0)) begin
                        r_fault <= 1'b1;
                        r_state <= S_FAULT;
                    end else if (w_leaf && w_need_ad) begin
`ifdef HPTW_ADUPDATE_EN
                        r_req    <= 1'b1;
                        r_wr     <= 1'b1;
                        r_wrdata <= r_pte | PTE_A | (r_miss_write ? PTE_D : 64'd0);
                        r_state  <= S_UPDATE;
`else
                        r_fault  <= 1'b1;
                        r_state  <= S_FAULT;
`endif
                    end else if (w_leaf) begin
                        r_tlbwrite <= 1'b1;
                        r_state    <= S_LEAF;
                    end else begin
                        r_level <= r_level - 2'd1;
                        r_adr   <= w_next_adr;
                        r_req   <= 1'b1;
                        r_state <= S_READ;
                    end
                end
`ifdef HPTW_ADUPDATE_EN
                S_UPDATE: begin
                    if (i_TLBFlush) r_abort <= 1'b1;
                    if (hptw.HPTWValid) begin
                        r_req      <= 1'b0;
                        r_wr       <= 1'b0;
                        r_pte      <= r_wrdata;
                        r_tlbwrite <= ~(r_abort | i_TLBFlush);
                        r_state    <= (r_abort | i_TLBFlush) ? S_IDLE : S_LEAF;
                    end
                end
`endif
                S_LEAF:  r_state <= S_IDLE;
                S_FAULT: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign hptw.HPTWReq = r_req;
    assign hptw.HPTWAdr = r_adr;
`ifdef HPTW_ADUPDATE_EN
    assign hptw.HPTWWr     = r_wr;
    assign hptw.HPTWWrData = r_wrdata;
`else
    assign hptw.HPTWWr     = 1'b0;
    assign hptw.HPTWWrData = 64'd0;
`endif

    assign o_PTE                = r_pte;
    assign o_PageTypeWriteVal   = r_level;
    assign o_TLBWrite           = r_tlbwrite;
    assign o_WalkerPageFault    = r_fault;
    assign o_DisableTranslation = (r_state != S_IDLE);

endmodule
